ascon_cmd_ctrl: RTL and testbench
=================================

// Module: ascon_cmd_ctrl
// PURPOSE
//  Synthesizable command sequencer that drives ascon_core from a 32-bit INS/DAT command stream.
//  Decodes instruction words, packs DAT words into CCW/CCSW-wide beats and generates eot/eoi.
//  Buffers core output (bdo) in a result FIFO, so output backpressure stalls the core cleanly.
//  Holds tag-verification results until the host accepts them. Sits between host bus/UART and ascon_core.
// PARAMETERS
//  CCW        32  bdi/bdo width; 32 or 64 (multiple of 32)
//  CCSW       32  key beat width; 32 or 64 (multiple of 32)
//  OUT_DEPTH  4   result FIFO entries; power of 2, >=2
// PORTS
//  clk             in   1        clock
//  rst             in   1        reset, synchronous, active-high
//  cmd_data        in   32       INS or DAT word
//  cmd_is_ins      in   1        1: cmd_data is INS {op[31:28],flags[27:24],len[23:0] bytes}
//  cmd_valid       in   1        command word valid
//  cmd_ready       out  1        command word accepted when valid&ready
//  key/key_valid/key_ready          out/out/in  CCSW/1/1  to ascon_core
//  bdi/bdi_valid/bdi_ready          out/out/in  CCW/1/1   to ascon_core
//  bdi_type/bdi_eot/bdi_eoi         out  4/1/1   to ascon_core (D_* codes from config.sv)
//  decrypt_in/hash_in               out  1/1     mode to ascon_core
//  bdo/bdo_valid/bdo_ready          in/in/out  CCW/1/1   from ascon_core
//  bdo_type/bdo_eot                 in   4/1     from ascon_core
//  msg_auth/msg_auth_valid/msg_auth_ready  in/in/out  1/1/1  from ascon_core
//  res_data/res_type/res_eot        out  CCW/4/1  FIFO head
//  res_valid       out  1        FIFO not empty
//  res_ready       in   1        pop when res_valid&res_ready
//  auth/auth_valid out  1/1      held tag-verification result
//  auth_ready      in   1        clears auth_valid
//  err             out  1        sticky protocol error, cleared only by rst
// BEHAVIOUR
//  Reset: state IDLE; key/key_valid/bdi/bdi_valid/bdi_eot/bdi_eoi/decrypt_in/hash_in/err/auth_valid/auth=0;
//   bdi_type=D_NULL; FIFO empty (res_valid=0); pack register and counters cleared. Reset mid-segment aborts it.
//  States: IDLE, LOAD, ISSUE.
//  IDLE: cmd_ready=1. On INS:
//   - op OP_ENC/OP_DEC/OP_HASH: registers decrypt_in/hash_in next cycle (0/0, 1/0, 0/1); stay IDLE.
//   - op OP_LD_KEY/NONCE/AD/MSG/TAG: W=CCSW for key, CCW otherwise.
//     beats=ceil(len*8/W); words=ceil(len/4). Latches op and flags[0]; goes to LOAD if len>0.
//     len==0: instruction consumed, no beats; stay IDLE.
//   - other op: err<=1, stay IDLE.
//   DAT in IDLE: word dropped, err<=1.
//  LOAD: cmd_ready=1. DAT word k of the beat goes to bits [32k+31:32k] (first word in LSBs).
//   Beat complete when W/32 words are collected, or the segment's last word arrives (upper words zero-padded).
//   On completion -> ISSUE.
//   INS in LOAD: segment aborted, err<=1, INS processed as in IDLE in the same cycle.
//  ISSUE: cmd_ready=0. Drives key_valid (key op) or bdi_valid + bdi_type (D_KEY n/a; D_NONCE/D_AD/D_MSG/D_TAG).
//   Last beat of segment: bdi_eot=1 and bdi_eoi=flags[0]. Outputs held stable until ready.
//   On handshake: beats-1; ->IDLE if 0, else ->LOAD.
//  Latency: the beat is presented the cycle after its last DAT word is accepted.
//   Throughput is 1 beat per W/32+1 cycles.
//  Result FIFO: push on bdo_valid&bdo_ready with {bdo,bdo_type,bdo_eot}; bdo_ready=!full (registered count).
//   Simultaneous push+pop when not full/empty: count unchanged. Pop when empty: ignored. Pointers wrap mod OUT_DEPTH.
//  Auth: msg_auth_ready=!auth_valid. On msg_auth_valid&msg_auth_ready: auth<=msg_auth, auth_valid<=1.
//   Cleared on auth_valid&auth_ready. A new capture and a clear in the same cycle: capture wins.
//  No combinational path from cmd_valid to bdi/key outputs.
// TESTING
//  CCW=CCSW=32: INS LD_KEY len=16 + 4 DAT -> 4 key beats, key_valid each, no eot; state IDLE after.
//  INS LD_AD len=5 flags=0 + DAT 0x11223344,0x55000000 -> 2 bdi beats D_AD; 2nd has eot=1, eoi=0.
//  CCW=64: INS LD_MSG len=12 flags=1 + DAT A,B,C -> beat0 {B,A}, beat1 {0,C} with eot=eoi=1.
//  OUT_DEPTH=4, res_ready=0, core emits 6 msg words -> bdo_ready=0 after 4 pushes.
//   Raising res_ready drains in order; no word lost or duplicated.
//  DAT in IDLE -> err=1, no bdi_valid. INS during LOAD -> err=1, new INS honoured.
//  rst asserted mid-LOAD -> all outputs return to reset values next cycle.
//  msg_auth_valid with auth_ready=0 -> auth held; msg_auth_ready=0 until auth_ready pulse.

Source files
------------

// File: rtl/ascon_cmd_ctrl.sv
// rtl/ascon_cmd_ctrl.sv - INS/DAT command sequencer, beat packer and result buffer for ascon_core
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_*                     32-bit command stream; INS = {op[31:28], flags[27:24], len[23:0] bytes}
//   key/key_valid/key_ready   CCSW-wide key beats to ascon_core
//   bdi/bdi_* , bdi_type      CCW-wide data beats to ascon_core with type, end-of-type, end-of-input
//   decrypt_in/hash_in        registered mode selection to ascon_core
//   bdo/bdo_*                 core output, pushed into the result FIFO
//   msg_auth*                 tag-verification result from the core
//   res_*                     result FIFO head and pop handshake
//   auth/auth_valid/auth_ready held tag-verification result
//   err                       sticky protocol error
module ascon_cmd_ctrl #(
    parameter int CCW       = 32,
    parameter int CCSW      = 32,
    parameter int OUT_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     cmd_data,
    input  logic            cmd_is_ins,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    output logic [CCSW-1:0] key,
    output logic            key_valid,
    input  logic            key_ready,
    output logic [CCW-1:0]  bdi,
    output logic            bdi_valid,
    input  logic            bdi_ready,
    output logic [3:0]      bdi_type,
    output logic            bdi_eot,
    output logic            bdi_eoi,
    output logic            decrypt_in,
    output logic            hash_in,
    input  logic [CCW-1:0]  bdo,
    input  logic            bdo_valid,
    output logic            bdo_ready,
    input  logic [3:0]      bdo_type,
    input  logic            bdo_eot,
    input  logic            msg_auth,
    input  logic            msg_auth_valid,
    output logic            msg_auth_ready,
    output logic [CCW-1:0]  res_data,
    output logic [3:0]      res_type,
    output logic            res_eot,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            auth,
    output logic            auth_valid,
    input  logic            auth_ready,
    output logic            err
);
    localparam logic [3:0] OP_ENC      = 4'h1;
    localparam logic [3:0] OP_DEC      = 4'h2;
    localparam logic [3:0] OP_HASH     = 4'h3;
    localparam logic [3:0] OP_LD_KEY   = 4'h4;
    localparam logic [3:0] OP_LD_NONCE = 4'h5;
    localparam logic [3:0] OP_LD_AD    = 4'h6;
    localparam logic [3:0] OP_LD_MSG   = 4'h7;
    localparam logic [3:0] OP_LD_TAG   = 4'h8;

    localparam logic [3:0] D_NULL  = 4'h0;
    localparam logic [3:0] D_NONCE = 4'h1;
    localparam logic [3:0] D_AD    = 4'h2;
    localparam logic [3:0] D_MSG   = 4'h3;
    localparam logic [3:0] D_TAG   = 4'h4;

    localparam int         PW      = (CCW > CCSW) ? CCW : CCSW;
    localparam logic [2:0] WPB_KEY = 3'(CCSW / 32);
    localparam logic [2:0] WPB_BDI = 3'(CCW / 32);
    localparam int         AW      = $clog2(OUT_DEPTH);
    localparam int         FW      = CCW + 5;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic          eoi_flag_q, eoi_flag_d;
    logic [22:0]   beats_q, beats_d;
    logic [22:0]   words_q, words_d;
    logic [2:0]    widx_q, widx_d;
    logic [PW-1:0] pack_q, pack_d;
    logic          decrypt_q, decrypt_d, hash_q, hash_d, err_q, err_d;

    logic [FW-1:0] fifo_mem_q [OUT_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          auth_q, auth_d, auth_valid_q, auth_valid_d;

    logic          ins_fire, dat_fire, is_key, handshake, issue, push, pop, capture;
    logic [2:0]    wpb, ins_wpb;
    logic [3:0]    ins_op;
    logic [23:0]   ins_len;
    logic [24:0]   words_sum;
    logic [23:0]   pairs_sum;
    logic [22:0]   ins_words, ins_beats;
    logic [FW-1:0] head;
    logic          unused_bits;

    assign ins_op    = cmd_data[31:28];
    assign ins_len   = cmd_data[23:0];
    // words = ceil(len/4); with two words per beat, beats = ceil(words/2) == ceil(len/8)
    assign words_sum = {1'b0, ins_len} + 25'd3;
    assign ins_words = words_sum[24:2];
    assign pairs_sum = {1'b0, ins_words} + 24'd1;
    assign ins_wpb   = (ins_op == OP_LD_KEY) ? WPB_KEY : WPB_BDI;
    assign ins_beats = (ins_wpb == 3'd2) ? pairs_sum[23:1] : ins_words;
    assign unused_bits = ^{cmd_data[27:25], words_sum[1:0], pairs_sum[0]};

    assign is_key    = (op_q == OP_LD_KEY);
    assign wpb       = is_key ? WPB_KEY : WPB_BDI;
    assign issue     = (state_q == S_ISSUE);
    assign handshake = is_key ? key_ready : bdi_ready;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        eoi_flag_d = eoi_flag_q;
        beats_d    = beats_q;
        words_d    = words_q;
        widx_d     = widx_q;
        pack_d     = pack_q;
        decrypt_d  = decrypt_q;
        hash_d     = hash_q;
        err_d      = err_q;
        cmd_ready  = (state_q != S_ISSUE);
        ins_fire   = cmd_valid && cmd_ready && cmd_is_ins;
        dat_fire   = cmd_valid && cmd_ready && !cmd_is_ins;

        case (state_q)
            S_IDLE: begin
                if (dat_fire) err_d = 1'b1;
            end
            S_LOAD: begin
                if (ins_fire) err_d = 1'b1;
                if (dat_fire) begin
                    pack_d[32*widx_q +: 32] = cmd_data;
                    words_d = words_q - 23'd1;
                    // A short final beat leaves its upper words at the zero the pack was cleared to
                    if (widx_q == wpb - 3'd1 || words_q == 23'd1) begin
                        widx_d  = 3'd0;
                        state_d = S_ISSUE;
                    end else begin
                        widx_d = widx_q + 3'd1;
                    end
                end
            end
            S_ISSUE: begin
                if (handshake) begin
                    beats_d = beats_q - 23'd1;
                    pack_d  = '0;
                    state_d = (beats_q == 23'd1) ? S_IDLE : S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An INS accepted in LOAD abandons the open segment and is decoded as if in IDLE
        if (ins_fire) begin
            state_d = S_IDLE;
            case (ins_op)
                OP_ENC:  begin decrypt_d = 1'b0; hash_d = 1'b0; end
                OP_DEC:  begin decrypt_d = 1'b1; hash_d = 1'b0; end
                OP_HASH: begin decrypt_d = 1'b0; hash_d = 1'b1; end
                OP_LD_KEY, OP_LD_NONCE, OP_LD_AD, OP_LD_MSG, OP_LD_TAG: begin
                    if (ins_len != 24'd0) begin
                        op_d       = ins_op;
                        eoi_flag_d = cmd_data[24];
                        beats_d    = ins_beats;
                        words_d    = ins_words;
                        widx_d     = 3'd0;
                        pack_d     = '0;
                        state_d    = S_LOAD;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    always_comb begin
        key_valid = issue && is_key;
        bdi_valid = issue && !is_key;
        key       = key_valid ? pack_q[CCSW-1:0] : '0;
        bdi       = bdi_valid ? pack_q[CCW-1:0] : '0;
        bdi_eot   = bdi_valid && (beats_q == 23'd1);
        bdi_eoi   = bdi_eot && eoi_flag_q;
        bdi_type  = D_NULL;
        if (bdi_valid) begin
            case (op_q)
                OP_LD_NONCE: bdi_type = D_NONCE;
                OP_LD_AD:    bdi_type = D_AD;
                OP_LD_MSG:   bdi_type = D_MSG;
                OP_LD_TAG:   bdi_type = D_TAG;
                default:     bdi_type = D_NULL;
            endcase
        end
    end

    assign decrypt_in = decrypt_q;
    assign hash_in    = hash_q;
    assign err        = err_q;

    // Result FIFO: bdo_ready comes from the registered count, so it never depends on res_ready
    always_comb begin
        bdo_ready = (count_q != (AW+1)'(OUT_DEPTH));
        res_valid = (count_q != '0);
        push      = bdo_valid && bdo_ready;
        pop       = res_valid && res_ready;
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        head     = fifo_mem_q[rd_ptr_q];
        res_data = res_valid ? head[FW-1:5] : '0;
        res_type = res_valid ? head[4:1] : 4'h0;
        res_eot  = res_valid && head[0];
    end

    // Capture needs auth_valid low and a clear needs it high, so capture-over-clear is structural
    always_comb begin
        msg_auth_ready = !auth_valid_q;
        capture        = msg_auth_valid && msg_auth_ready;
        auth_d         = capture ? msg_auth : auth_q;
        if (capture) auth_valid_d = 1'b1;
        else if (auth_valid_q && auth_ready) auth_valid_d = 1'b0;
        else auth_valid_d = auth_valid_q;
        auth       = auth_q;
        auth_valid = auth_valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= 4'h0;
            eoi_flag_q   <= 1'b0;
            beats_q      <= '0;
            words_q      <= '0;
            widx_q       <= 3'd0;
            pack_q       <= '0;
            decrypt_q    <= 1'b0;
            hash_q       <= 1'b0;
            err_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            auth_q       <= 1'b0;
            auth_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            eoi_flag_q   <= eoi_flag_d;
            beats_q      <= beats_d;
            words_q      <= words_d;
            widx_q       <= widx_d;
            pack_q       <= pack_d;
            decrypt_q    <= decrypt_d;
            hash_q       <= hash_d;
            err_q        <= err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            auth_q       <= auth_d;
            auth_valid_q <= auth_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {bdo, bdo_type, bdo_eot};
    end
endmodule

// File: tb/tb_ascon_cmd_ctrl.sv
// tb/tb_ascon_cmd_ctrl.sv - directed self-checking bench for ascon_cmd_ctrl
module tb_ascon_cmd_ctrl;
    localparam logic [3:0] OP_ENC = 4'h1, OP_DEC = 4'h2, OP_HASH = 4'h3, OP_LD_KEY = 4'h4;
    localparam logic [3:0] OP_LD_NONCE = 4'h5, OP_LD_AD = 4'h6, OP_LD_MSG = 4'h7;
    localparam logic [3:0] D_NULL = 4'h0, D_NONCE = 4'h1, D_AD = 4'h2, D_MSG = 4'h3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [31:0] cmd_data;  logic cmd_is_ins, cmd_valid, cmd_ready;
    logic [31:0] key;       logic key_valid, key_ready;
    logic [31:0] bdi;       logic bdi_valid, bdi_ready, bdi_eot, bdi_eoi;
    logic [3:0]  bdi_type;  logic decrypt_in, hash_in;
    logic [31:0] bdo;       logic bdo_valid, bdo_ready, bdo_eot;
    logic [3:0]  bdo_type;  logic msg_auth, msg_auth_valid, msg_auth_ready;
    logic [31:0] res_data;  logic [3:0] res_type; logic res_eot, res_valid, res_ready;
    logic auth, auth_valid, auth_ready, err;

    logic [31:0] b_cmd_data; logic b_cmd_is_ins, b_cmd_valid, b_cmd_ready;
    logic [31:0] b_key;      logic b_key_valid;
    logic [63:0] b_bdi;      logic b_bdi_valid, b_bdi_ready, b_bdi_eot, b_bdi_eoi;
    logic [3:0]  b_bdi_type; logic b_decrypt_in, b_hash_in, b_bdo_ready, b_msg_auth_ready;
    logic [63:0] b_res_data; logic [3:0] b_res_type; logic b_res_eot, b_res_valid;
    logic b_auth, b_auth_valid, b_err;

    int vectors = 0;
    int miscompares = 0;

    logic [69:0] a_bdi_log[$];
    logic [69:0] b_bdi_log[$];
    logic [32:0] a_key_log[$];
    logic [36:0] a_res_log[$];

    ascon_cmd_ctrl #(.CCW(32), .CCSW(32), .OUT_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_is_ins(cmd_is_ins), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .key(key), .key_valid(key_valid), .key_ready(key_ready), .bdi(bdi),
        .bdi_valid(bdi_valid), .bdi_ready(bdi_ready), .bdi_type(bdi_type), .bdi_eot(bdi_eot),
        .bdi_eoi(bdi_eoi), .decrypt_in(decrypt_in), .hash_in(hash_in), .bdo(bdo), .bdo_valid(bdo_valid),
        .bdo_ready(bdo_ready), .bdo_type(bdo_type), .bdo_eot(bdo_eot), .msg_auth(msg_auth),
        .msg_auth_valid(msg_auth_valid), .msg_auth_ready(msg_auth_ready), .res_data(res_data),
        .res_type(res_type), .res_eot(res_eot), .res_valid(res_valid), .res_ready(res_ready),
        .auth(auth), .auth_valid(auth_valid), .auth_ready(auth_ready), .err(err)
    );

    ascon_cmd_ctrl #(.CCW(64), .CCSW(32), .OUT_DEPTH(4)) u_dut64 (
        .clk(clk), .rst(rst), .cmd_data(b_cmd_data), .cmd_is_ins(b_cmd_is_ins), .cmd_valid(b_cmd_valid),
        .cmd_ready(b_cmd_ready), .key(b_key), .key_valid(b_key_valid), .key_ready(1'b1), .bdi(b_bdi),
        .bdi_valid(b_bdi_valid), .bdi_ready(b_bdi_ready), .bdi_type(b_bdi_type), .bdi_eot(b_bdi_eot),
        .bdi_eoi(b_bdi_eoi), .decrypt_in(b_decrypt_in), .hash_in(b_hash_in), .bdo(64'h0),
        .bdo_valid(1'b0), .bdo_ready(b_bdo_ready), .bdo_type(4'h0), .bdo_eot(1'b0), .msg_auth(1'b0),
        .msg_auth_valid(1'b0), .msg_auth_ready(b_msg_auth_ready), .res_data(b_res_data),
        .res_type(b_res_type), .res_eot(b_res_eot), .res_valid(b_res_valid), .res_ready(1'b0),
        .auth(b_auth), .auth_valid(b_auth_valid), .auth_ready(1'b0), .err(b_err)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (key_valid && key_ready) a_key_log.push_back({bdi_eot, key});
            if (bdi_valid && bdi_ready) a_bdi_log.push_back({bdi_type, bdi_eot, bdi_eoi, 32'h0, bdi});
            if (b_bdi_valid && b_bdi_ready) b_bdi_log.push_back({b_bdi_type, b_bdi_eot, b_bdi_eoi, b_bdi});
            if (res_valid && res_ready) a_res_log.push_back({res_type, res_eot, res_data});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    // Called and returns at posedge+1; the word is accepted on the posedge before return
    task automatic send(input bit sel, input logic ins, input logic [31:0] d);
        bit done;
        done = 1'b0;
        if (sel) begin b_cmd_valid = 1'b1; b_cmd_is_ins = ins; b_cmd_data = d; end
        else begin cmd_valid = 1'b1; cmd_is_ins = ins; cmd_data = d; end
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if ((sel ? b_cmd_ready : cmd_ready) === 1'b1) done = 1'b1;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        b_cmd_valid = 1'b0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL send_accept: word %h got cmd_ready=0 want accepted", d);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({key_valid, bdi_valid, bdi_eot, bdi_eoi, decrypt_in, hash_in, err, auth_valid, auth, res_valid} !== 10'h0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 0000000000",
                {key_valid, bdi_valid, bdi_eot, bdi_eoi, decrypt_in, hash_in, err, auth_valid, auth, res_valid});
        end
        vectors++;
        if ({bdi_type, key, bdi} !== {D_NULL, 64'h0}) begin
            miscompares++;
            $display("FAIL reset_data: got type=%h key=%h bdi=%h want 0", bdi_type, key, bdi);
        end
        vectors++;
        if ({cmd_ready, bdo_ready, msg_auth_ready} !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 111", {cmd_ready, bdo_ready, msg_auth_ready});
        end
        vectors++;
        if ({b_cmd_ready, b_bdi_valid, b_err, b_res_valid} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_dut64: got %b want 1000", {b_cmd_ready, b_bdi_valid, b_err, b_res_valid});
        end
    endtask

    task automatic test_mode();
        logic [3:0] ops [3];
        logic [1:0] exp [3];
        ops = '{OP_DEC, OP_HASH, OP_ENC};
        exp = '{2'b10, 2'b01, 2'b00};
        for (int i = 0; i < 3; i++) begin
            send(0, 1'b1, {ops[i], 28'h0});
            vectors++;
            if ({decrypt_in, hash_in} !== exp[i]) begin
                miscompares++;
                $display("FAIL mode_op%0h: got dec/hash=%b want %b", ops[i], {decrypt_in, hash_in}, exp[i]);
            end
        end
    endtask

    task automatic test_key();
        logic [31:0] w [4];
        logic [32:0] got;
        w = '{32'h0001_0203, 32'h0405_0607, 32'h0809_0A0B, 32'h0C0D_0E0F};
        a_key_log.delete();
        a_bdi_log.delete();
        send(0, 1'b1, {OP_LD_KEY, 4'h0, 24'd16});
        for (int i = 0; i < 4; i++) send(0, 1'b0, w[i]);
        step(3);
        vectors++;
        if (a_key_log.size() != 4 || a_bdi_log.size() != 0) begin
            miscompares++;
            $display("FAIL key_count: got key=%0d bdi=%0d want key=4 bdi=0", a_key_log.size(), a_bdi_log.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < a_key_log.size()) ? a_key_log[i] : '1;
            vectors++;
            if (got !== {1'b0, w[i]}) begin
                miscompares++;
                $display("FAIL key_beat%0d: got %h want %h", i, got, {1'b0, w[i]});
            end
        end
        vectors++;
        if ({cmd_ready, key_valid, err} !== 3'b100) begin
            miscompares++;
            $display("FAIL key_idle: got ready/kv/err=%b want 100", {cmd_ready, key_valid, err});
        end
    endtask

    task automatic test_ad();
        logic [69:0] got;
        logic [69:0] exp [2];
        exp = '{{D_AD, 2'b00, 64'h0000_0000_1122_3344}, {D_AD, 2'b10, 64'h0000_0000_5500_0000}};
        a_bdi_log.delete();
        bdi_ready = 1'b0;
        send(0, 1'b1, {OP_LD_AD, 4'h0, 24'd5});
        send(0, 1'b0, 32'h1122_3344);
        vectors++;
        if ({bdi_valid, cmd_ready, bdi_type, bdi_eot, bdi} !== {2'b10, D_AD, 1'b0, 32'h1122_3344}) begin
            miscompares++;
            $display("FAIL ad_latency: got v/r=%b type=%h eot=%b bdi=%h want 10 2 0 11223344",
                {bdi_valid, cmd_ready}, bdi_type, bdi_eot, bdi);
        end
        step(2);
        vectors++;
        if ({bdi_valid, bdi} !== {1'b1, 32'h1122_3344}) begin
            miscompares++;
            $display("FAIL ad_hold: got valid=%b bdi=%h want 1 11223344", bdi_valid, bdi);
        end
        bdi_ready = 1'b1;
        send(0, 1'b0, 32'h5500_0000);
        step(2);
        vectors++;
        if (a_bdi_log.size() != 2) begin
            miscompares++;
            $display("FAIL ad_count: got %0d want 2", a_bdi_log.size());
        end
        for (int i = 0; i < 2; i++) begin
            got = (i < a_bdi_log.size()) ? a_bdi_log[i] : '1;
            vectors++;
            if (got !== exp[i]) begin
                miscompares++;
                $display("FAIL ad_beat%0d: got %h want %h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_ccw64();
        logic [69:0] got;
        logic [69:0] exp [2];
        exp = '{{D_MSG, 2'b00, 64'hB1B1_B1B1_A0A0_A0A0}, {D_MSG, 2'b11, 64'h0000_0000_C2C2_C2C2}};
        b_bdi_log.delete();
        send(1, 1'b1, {OP_LD_MSG, 4'h1, 24'd12});
        send(1, 1'b0, 32'hA0A0_A0A0);
        send(1, 1'b0, 32'hB1B1_B1B1);
        send(1, 1'b0, 32'hC2C2_C2C2);
        vectors++;
        if ({b_bdi_valid, b_bdi_eot, b_bdi_eoi} !== 3'b111) begin
            miscompares++;
            $display("FAIL c64_latency: got v/eot/eoi=%b want 111", {b_bdi_valid, b_bdi_eot, b_bdi_eoi});
        end
        step(2);
        vectors++;
        if (b_bdi_log.size() != 2) begin
            miscompares++;
            $display("FAIL c64_count: got %0d want 2", b_bdi_log.size());
        end
        for (int i = 0; i < 2; i++) begin
            got = (i < b_bdi_log.size()) ? b_bdi_log[i] : '1;
            vectors++;
            if (got !== exp[i]) begin
                miscompares++;
                $display("FAIL c64_beat%0d: got %h want %h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_fifo();
        int pushed;
        logic rdy;
        logic [36:0] got, exp;
        pushed = 0;
        a_res_log.delete();
        res_ready = 1'b0;
        bdo_valid = 1'b1;
        bdo_type = D_MSG;
        for (int c = 0; c < 40 && pushed < 6; c++) begin
            if (c == 8) begin
                vectors++;
                if ({pushed[3:0], bdo_ready, res_valid, res_data} !== {4'd4, 2'b01, 32'hF000_0000}) begin
                    miscompares++;
                    $display("FAIL fifo_full: got pushed=%0d bdo_ready=%b res_valid=%b head=%h want 4 0 1 f0000000",
                        pushed, bdo_ready, res_valid, res_data);
                end
                res_ready = 1'b1;
            end
            bdo = 32'hF000_0000 + 32'(pushed);
            bdo_eot = (pushed == 5);
            @(negedge clk);
            rdy = bdo_ready;
            @(posedge clk);
            #1;
            if (rdy) pushed++;
        end
        bdo_valid = 1'b0;
        for (int c = 0; c < 20 && res_valid; c++) step(1);
        step(1);
        res_ready = 1'b0;
        vectors++;
        if (a_res_log.size() != 6 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fifo_drain: got %0d popped res_valid=%b want 6 0", a_res_log.size(), res_valid);
        end
        for (int i = 0; i < 6; i++) begin
            got = (i < a_res_log.size()) ? a_res_log[i] : '1;
            exp = {D_MSG, (i == 5), 32'hF000_0000 + 32'(i)};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL fifo_pop%0d: got %h want %h", i, got, exp);
            end
        end
    endtask

    task automatic test_auth();
        auth_ready = 1'b0;
        msg_auth = 1'b1;
        msg_auth_valid = 1'b1;
        step(1);
        msg_auth_valid = 1'b0;
        vectors++;
        if ({auth_valid, auth, msg_auth_ready} !== 3'b110) begin
            miscompares++;
            $display("FAIL auth_capture: got v/a/r=%b want 110", {auth_valid, auth, msg_auth_ready});
        end
        msg_auth = 1'b0;
        msg_auth_valid = 1'b1;
        step(2);
        msg_auth_valid = 1'b0;
        vectors++;
        if ({auth_valid, auth, msg_auth_ready} !== 3'b110) begin
            miscompares++;
            $display("FAIL auth_hold: got v/a/r=%b want 110", {auth_valid, auth, msg_auth_ready});
        end
        auth_ready = 1'b1;
        step(1);
        auth_ready = 1'b0;
        vectors++;
        if ({auth_valid, msg_auth_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL auth_clear: got v/r=%b want 01", {auth_valid, msg_auth_ready});
        end
        msg_auth_valid = 1'b1;
        step(1);
        msg_auth_valid = 1'b0;
        vectors++;
        if ({auth_valid, auth} !== 2'b10) begin
            miscompares++;
            $display("FAIL auth_recapture: got v/a=%b want 10", {auth_valid, auth});
        end
        auth_ready = 1'b1;
        step(1);
        auth_ready = 1'b0;
    endtask

    task automatic test_err_dat_idle();
        do_reset();
        a_bdi_log.delete();
        send(0, 1'b0, 32'h0000_1234);
        step(2);
        vectors++;
        if ({err, cmd_ready, bdi_valid} !== 3'b110 || a_bdi_log.size() != 0) begin
            miscompares++;
            $display("FAIL dat_idle: got err/ready/valid=%b beats=%0d want 110 0",
                {err, cmd_ready, bdi_valid}, a_bdi_log.size());
        end
    endtask

    task automatic test_ins_during_load();
        logic [69:0] got;
        logic [69:0] exp [2];
        exp = '{{D_AD, 2'b00, 64'h0000_0000_AAAA_0001}, {D_NONCE, 2'b10, 64'h0000_0000_BBBB_0002}};
        do_reset();
        a_bdi_log.delete();
        send(0, 1'b1, {OP_LD_AD, 4'h0, 24'd8});
        send(0, 1'b0, 32'hAAAA_0001);
        step(2);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_pre: got err=%b want 0", err);
        end
        send(0, 1'b1, {OP_LD_NONCE, 4'h0, 24'd4});
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_err: got err=%b want 1", err);
        end
        send(0, 1'b0, 32'hBBBB_0002);
        step(2);
        for (int i = 0; i < 2; i++) begin
            got = (i < a_bdi_log.size()) ? a_bdi_log[i] : '1;
            vectors++;
            if (got !== exp[i]) begin
                miscompares++;
                $display("FAIL abort_beat%0d: got %h want %h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_bad_op();
        do_reset();
        send(0, 1'b1, {4'hF, 28'h0});
        vectors++;
        if ({err, cmd_ready, decrypt_in, hash_in} !== 4'b1100) begin
            miscompares++;
            $display("FAIL bad_op: got err/ready/dec/hash=%b want 1100", {err, cmd_ready, decrypt_in, hash_in});
        end
    endtask

    task automatic test_rst_mid_load();
        send(0, 1'b1, {OP_DEC, 28'h0});
        send(0, 1'b1, {OP_LD_MSG, 4'h1, 24'd8});
        send(0, 1'b0, 32'h1357_9BDF);
        bdo = 32'h5A5A_5A5A;
        bdo_valid = 1'b1;
        msg_auth = 1'b1;
        msg_auth_valid = 1'b1;
        step(2);
        bdo_valid = 1'b0;
        msg_auth_valid = 1'b0;
        vectors++;
        if ({err, decrypt_in, res_valid, auth_valid, cmd_ready} !== 5'b11111) begin
            miscompares++;
            $display("FAIL rst_pre: got err/dec/res/auth/ready=%b want 11111",
                {err, decrypt_in, res_valid, auth_valid, cmd_ready});
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        vectors++;
        if ({key_valid, bdi_valid, bdi_eot, bdi_eoi, decrypt_in, hash_in, err, auth_valid, auth, res_valid} !== 10'h0) begin
            miscompares++;
            $display("FAIL rst_flags: got %b want 0000000000",
                {key_valid, bdi_valid, bdi_eot, bdi_eoi, decrypt_in, hash_in, err, auth_valid, auth, res_valid});
        end
        vectors++;
        if ({bdi_type, cmd_ready, bdo_ready, msg_auth_ready} !== {D_NULL, 3'b111}) begin
            miscompares++;
            $display("FAIL rst_ready: got type=%h ready=%b want 0 111", bdi_type, {cmd_ready, bdo_ready, msg_auth_ready});
        end
        a_bdi_log.delete();
        send(0, 1'b0, 32'h2468_ACE0);
        step(2);
        vectors++;
        if (err !== 1'b1 || a_bdi_log.size() != 0) begin
            miscompares++;
            $display("FAIL rst_idle: got err=%b beats=%0d want 1 0", err, a_bdi_log.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_data = '0; cmd_is_ins = 1'b0; cmd_valid = 1'b0;
        b_cmd_data = '0; b_cmd_is_ins = 1'b0; b_cmd_valid = 1'b0;
        key_ready = 1'b1; bdi_ready = 1'b1; b_bdi_ready = 1'b1;
        bdo = '0; bdo_valid = 1'b0; bdo_type = 4'h0; bdo_eot = 1'b0;
        msg_auth = 1'b0; msg_auth_valid = 1'b0; res_ready = 1'b0; auth_ready = 1'b0;
        #1;
        test_reset();
        test_mode();
        test_key();
        test_ad();
        test_ccw64();
        test_fifo();
        test_auth();
        test_err_dat_idle();
        test_ins_during_load();
        test_bad_op();
        test_rst_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
